wrom_param: RTL and testbench

WROM_PARAM -- requirements
Module: wrom_param

---
 rtl/wrom_param.sv | 136 +++++++++++++
 tb/tb_wrom_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wrom_param.sv
// Twiddle ROM sequencer. It streams G = N/LANES groups of LANES twiddle words.
// Each group is held for HOLD enabled cycles, in the stage order (b * 4^s) mod G.
module wrom_lane #(
  parameter int NB    = 9,
  parameter int N     = 32,
  parameter int LANES = 4,
  parameter int LANE  = 0,
  parameter int GW    = 3,
  parameter logic [N*NB-1:0] TW_R = '0,
  parameter logic [N*NB-1:0] TW_I = '0
) (
  input  logic [GW-1:0] grp,
  output logic [NB-1:0] re,
  output logic [NB-1:0] im
);
  localparam int G = N / LANES;

  logic [NB-1:0] tr [G];
  logic [NB-1:0] ti [G];

  for (genvar g = 0; g < G; g++) begin : g_ent
    assign tr[g] = TW_R[(g*LANES+LANE)*NB +: NB];
    assign ti[g] = TW_I[(g*LANES+LANE)*NB +: NB];
  end

  assign re = tr[grp];
  assign im = ti[grp];
endmodule

module wrom_param #(
  parameter int NB      = 9,
  parameter int N       = 32,
  parameter int LANES   = 4,
  parameter int HOLD    = 4,
  parameter int NSTAGES = 2,
  // Unity in the short-float format: leading 01, all other bits zero.
  parameter logic [N*NB-1:0] TW_R = {N{{2'b01, {(NB-2){1'b0}}}}},
  parameter logic [N*NB-1:0] TW_I = '0
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          START,
  input  logic [((NSTAGES > 1) ? $clog2(NSTAGES) : 1)-1:0] STAGE,
  input  logic                                          EN,
  output logic [NB*LANES-1:0]                           OR,
  output logic [NB*LANES-1:0]                           OI,
  output logic                                          VALID,
  output logic                                          LAST,
  output logic                                          RDY,
  output logic                                          BUSY,
  output logic                                          ERR
);
  localparam int G  = N / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int SW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]               st;
  logic [HW-1:0]            h;
  logic [GW-1:0]            b;
  logic [GW-1:0]            grp;
  logic [SW-1:0]            stg;
  logic                     run;
  logic                     fin;
  logic                     bad;
  logic [LANES-1:0][NB-1:0] lr;
  logic [LANES-1:0][NB-1:0] li;

  assign run = (st == RUN);
  assign fin = (b == GW'(G-1)) && (h == HW'(HOLD-1));
  assign bad = 32'(STAGE) >= 32'(NSTAGES);
  // G is a power of two, so truncating to GW bits gives (b * 4^s) mod G.
  assign grp = b << {stg, 1'b0};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    wrom_lane #(
      .NB(NB), .N(N), .LANES(LANES), .LANE(l), .GW(GW),
      .TW_R(TW_R), .TW_I(TW_I)
    ) u_lane (
      .grp (grp),
      .re  (lr[l]),
      .im  (li[l])
    );
  end

  // The counters run one cycle ahead of the output registers.
  // A single EN therefore advances both and keeps them aligned through stalls.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      st    <= IDLE;
      h     <= '0;
      b     <= '0;
      stg   <= '0;
      OR    <= '0;
      OI    <= '0;
      VALID <= 1'b0;
      LAST  <= 1'b0;
      RDY   <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      ERR <= 1'b0;
      RDY <= 1'b0;
      if (START && bad) begin
        ERR <= 1'b1;
      end else if (START) begin
        st    <= RUN;
        h     <= '0;
        b     <= '0;
        stg   <= SW'(STAGE);
        VALID <= 1'b0;
        LAST  <= 1'b0;
      end else if (EN) begin
        VALID <= run;
        LAST  <= run && fin;
        RDY   <= VALID && LAST;
        if (run) begin
          OR <= lr;
          OI <= li;
          if (fin) begin
            st <= IDLE;
          end else if (h == HW'(HOLD-1)) begin
            h <= '0;
            b <= b + 1'b1;
          end else begin
            h <= h + 1'b1;
          end
        end
      end
    end
  end

  assign BUSY = run | VALID;
endmodule

// File: tb/tb_wrom_param.sv
// Randomised and directed bench for wrom_param with ramp twiddle tables.
// A sequence-index reference model is checked every cycle.
module tb_wrom_param;
  localparam int NB = 9, N = 32, LANES = 4, HOLD = 4;
  localparam int G = N / LANES, SEQ = G * HOLD, W = NB * LANES, VW = 2*W + 5;

  function automatic logic [N*NB-1:0] ramp(input bit inv);
    logic [N*NB-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*NB +: NB] = NB'(inv ? N-1-k : k);
    return v;
  endfunction

  localparam logic [N*NB-1:0] TR = ramp(1'b0);
  localparam logic [N*NB-1:0] TI = ramp(1'b1);

  logic CLK = 0, RST = 0, START = 0, START1 = 0, EN = 0;
  logic [0:0] STAGE = '0;
  logic [W-1:0] OR, OI, OR1, OI1;
  logic VALID, LAST, RDY, BUSY, ERR;
  logic VALID1, LAST1, RDY1, BUSY1, ERR1;
  int tests = 0, fails = 0;

  wrom_param #(.NB(NB), .N(N), .LANES(LANES), .HOLD(HOLD), .NSTAGES(2),
               .TW_R(TR), .TW_I(TI)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STAGE(STAGE), .EN(EN),
    .OR(OR), .OI(OI), .VALID(VALID), .LAST(LAST), .RDY(RDY), .BUSY(BUSY), .ERR(ERR));

  wrom_param #(.NB(NB), .N(N), .LANES(LANES), .HOLD(HOLD), .NSTAGES(1),
               .TW_R(TR), .TW_I(TI)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .STAGE(STAGE), .EN(EN),
    .OR(OR1), .OI(OI1), .VALID(VALID1), .LAST(LAST1), .RDY(RDY1), .BUSY(BUSY1), .ERR(ERR1));

  always #5 CLK = ~CLK;

  // The model has three phases: 0 idle, 1 waiting for first output, 2 showing item m_k.
  int m_phase = 0, m_k = 0, m_s = 0;
  logic [W-1:0] m_or = '0, m_oi = '0;
  bit m_rdy = 0, m_err = 0;

  function automatic int grp_of(int k, int s);
    return ((k / HOLD) * (1 << (2*s))) % G;
  endfunction

  task automatic load();
    int g;
    g = grp_of(m_k, m_s);
    for (int l = 0; l < LANES; l++) begin
      m_or[l*NB +: NB] = NB'(g*LANES + l);
      m_oi[l*NB +: NB] = NB'(N-1 - (g*LANES + l));
    end
  endtask

  task automatic model_edge();
    m_rdy = 0; m_err = 0;
    if (!RST) begin
      m_phase = 0; m_k = 0; m_s = 0; m_or = '0; m_oi = '0;
    end else if (START && int'(STAGE) >= 2) begin
      m_err = 1;
    end else if (START) begin
      m_phase = 1; m_s = int'(STAGE);
    end else if (EN) begin
      if (m_phase == 1) begin
        m_phase = 2; m_k = 0; load();
      end else if (m_phase == 2) begin
        if (m_k == SEQ-1) begin m_phase = 0; m_rdy = 1; end
        else begin m_k++; load(); end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_or, m_oi, m_phase == 2, (m_phase == 2) && (m_k == SEQ-1), m_rdy, m_phase != 0, m_err};
  endfunction
  function automatic logic [VW-1:0] obs();
    return {OR, OI, VALID, LAST, RDY, BUSY, ERR};
  endfunction
  function automatic logic [VW-1:0] obs1();
    return {OR1, OI1, VALID1, LAST1, RDY1, BUSY1, ERR1};
  endfunction

  task automatic tick(input bit st, input bit sg, input bit en, input bit rs, input bit st1 = 1'b0);
    START = st; STAGE = sg; EN = en; RST = rs; START1 = st1;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    tests++;
    if (obs() !== '0) begin fails++; $display("FAIL reset: got %h want 0", obs()); end
    tests++;
    if (obs1() !== '0) begin fails++; $display("FAIL reset1: got %h want 0", obs1()); end
  endtask

  task automatic test_stage0();
    int vcnt, last_v, last_i, rdy_i;
    vcnt = 0; last_v = -1; last_i = -1; rdy_i = -1;
    tick(1, 0, 1, 1);
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 1, 1);
      tests++;
      if (obs() !== exp_vec()) begin fails++; $display("FAIL stage0 cyc %0d: got %h want %h", i, obs(), exp_vec()); end
      if (VALID) vcnt++;
      if (VALID && vcnt == 1) begin
        tests++;
        if (OR !== {9'd3, 9'd2, 9'd1, 9'd0}) begin fails++; $display("FAIL stage0 first: got %h want %h", OR, {9'd3, 9'd2, 9'd1, 9'd0}); end
      end
      if (LAST) begin
        last_v = vcnt; last_i = i;
        tests++;
        if (OR !== {9'd31, 9'd30, 9'd29, 9'd28}) begin fails++; $display("FAIL stage0 lastgrp: got %h want %h", OR, {9'd31, 9'd30, 9'd29, 9'd28}); end
      end
      if (RDY) rdy_i = i;
    end
    tests++;
    if (last_v != 32) begin fails++; $display("FAIL stage0 last_at: got %0d want 32", last_v); end
    tests++;
    if (rdy_i != last_i + 1) begin fails++; $display("FAIL stage0 rdy_at: got %0d want %0d", rdy_i, last_i + 1); end
  endtask

  task automatic test_stage1();
    int vcnt;
    logic [W-1:0] want;
    vcnt = 0;
    tick(1, 1, 1, 1);
    for (int i = 0; i < 36; i++) begin
      tick(0, 0, 1, 1);
      tests++;
      if (obs() !== exp_vec()) begin fails++; $display("FAIL stage1 cyc %0d: got %h want %h", i, obs(), exp_vec()); end
      if (VALID) begin
        want = ((vcnt / 4) % 2) ? {9'd19, 9'd18, 9'd17, 9'd16} : {9'd3, 9'd2, 9'd1, 9'd0};
        tests++;
        if (OR !== want) begin fails++; $display("FAIL stage1 grp v%0d: got %h want %h", vcnt, OR, want); end
        vcnt++;
      end
    end
  endtask

  task automatic test_stall();
    int left, last_n;
    bit done, en;
    left = 0; last_n = -1; done = 0;
    tick(1, 0, 1, 1);
    for (int n = 0; n < 45; n++) begin
      if (!done && m_phase == 2 && m_k == 2*HOLD + 1) begin done = 1; left = 5; end
      en = (left == 0);
      if (!en) left--;
      tick(0, 0, en, 1);
      tests++;
      if (obs() !== exp_vec()) begin fails++; $display("FAIL stall cyc %0d: got %h want %h", n, obs(), exp_vec()); end
      if (!en) begin
        tests++;
        if (OR !== {9'd11, 9'd10, 9'd9, 9'd8} || OI !== {9'd20, 9'd21, 9'd22, 9'd23})
          begin fails++; $display("FAIL stall frozen: got %h/%h want group 2", OR, OI); end
      end
      if (LAST && last_n < 0) last_n = n;
    end
    tests++;
    if (last_n != 36) begin fails++; $display("FAIL stall last_at: got %0d want 36", last_n); end
  endtask

  task automatic test_restart();
    int rdy_cnt, rs_n, fv_n;
    bit done;
    rdy_cnt = 0; rs_n = -1; fv_n = -1; done = 0;
    tick(1, 0, 1, 1);
    for (int n = 0; n < 80; n++) begin
      if (!done && m_phase == 2 && m_k == 5*HOLD) begin done = 1; rs_n = n; tick(1, 1, 1, 1); end
      else tick(0, 0, 1, 1);
      tests++;
      if (obs() !== exp_vec()) begin fails++; $display("FAIL restart cyc %0d: got %h want %h", n, obs(), exp_vec()); end
      if (RDY) rdy_cnt++;
      if (done && fv_n < 0 && VALID) begin
        fv_n = n;
        tests++;
        if (OR !== {9'd3, 9'd2, 9'd1, 9'd0}) begin fails++; $display("FAIL restart grp0: got %h want %h", OR, {9'd3, 9'd2, 9'd1, 9'd0}); end
      end
    end
    tests++;
    if (fv_n != rs_n + 1 || rs_n < 0) begin fails++; $display("FAIL restart first_valid: got %0d want %0d", fv_n, rs_n + 1); end
    tests++;
    if (rdy_cnt != 1) begin fails++; $display("FAIL restart rdy_count: got %0d want 1", rdy_cnt); end
  endtask

  task automatic test_illegal();
    int rdy_seen;
    rdy_seen = 0;
    tick(0, 1, 1, 1, 1);
    tests++;
    if ({ERR1, BUSY1, VALID1} !== 3'b100) begin fails++; $display("FAIL illegal err: got %b want 100", {ERR1, BUSY1, VALID1}); end
    tick(0, 0, 1, 1, 0);
    tests++;
    if ({ERR1, BUSY1, VALID1} !== 3'b000) begin fails++; $display("FAIL illegal once: got %b want 000", {ERR1, BUSY1, VALID1}); end
    tick(0, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 1, 0);
    tests++;
    if ({VALID1, BUSY1} !== 2'b11) begin fails++; $display("FAIL illegal run: got %b want 11", {VALID1, BUSY1}); end
    tick(0, 0, 1, 0, 0);
    tests++;
    if (obs1() !== '0) begin fails++; $display("FAIL reset_mid: got %h want 0", obs1()); end
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 1, 1, 0);
      if (RDY1) rdy_seen++;
    end
    tests++;
    if (rdy_seen != 0 || BUSY1 !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %0d/%b want 0/0", rdy_seen, BUSY1); end
  endtask

  task automatic test_random();
    bit st, sg, en, rs;
    for (int i = 0; i < 1500; i++) begin
      st = (m_phase == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 2);
      sg = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 199) != 0);
      tick(st, sg, en, rs);
      tests++;
      if (obs() !== exp_vec()) begin
        fails++;
        if (fails < 20) $display("FAIL random cyc %0d: got %h want %h", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_stage0();
    test_stage1();
    test_stall();
    test_restart();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
